vector_reduction_unit: RTL and testbench
========================================

// Module: vector_reduction_unit
// PURPOSE
//  Runtime-configurable vector reduction engine for the RS5 vector unit (vred*.vs).
//  Accepts a vs2 register group one VLEN-bit beat per cycle (LMUL 1..LMUL_MAX), folds beats
//  lane-wise into an accumulator, then folds the accumulator in halves.
//  Finally it combines the result with the vs1[0] seed scalar. Op and SEW are runtime inputs.
// PARAMETERS
//  VLEN      64  register width in bits (power of 2, >= ELEN)
//  ELEN      64  maximum SEW; result width
//  LMUL_MAX  8   maximum beats per reduction (power of 2)
//  (derived) NLANE=VLEN/8 max elements per beat; VL_W=$clog2(LMUL_MAX*VLEN/8)+1
// PORTS
//  clk          in   1      clock
//  reset_n      in   1      asynchronous, active-low reset
//  start_i      in   1      begin reduction; sampled only in IDLE
//  op_i         in   3      0 SUM,1 AND,2 OR,3 XOR,4 MINU,5 MIN,6 MAXU,7 MAX (latched at start)
//  sew_i        in   2      0=8,1=16,2=32,3=64 bits; values above ELEN illegal (latched at start)
//  vl_i         in   VL_W   active element count (latched at start)
//  vm_i         in   1      1 = unmasked (latched at start)
//  seed_i       in   ELEN   vs1[0]; low SEW bits used (latched at start)
//  in_valid_i   in   1      beat valid
//  in_ready_o   out  1      beat accepted when in_valid_i & in_ready_o
//  in_data_i    in   VLEN   vs2 beat, element k in bits [k*SEW +: SEW]
//  in_mask_i    in   NLANE  v0 bits for this beat's elements; low VLEN/SEW bits used
//  in_last_i    in   1      final beat of the group
//  abort_i      in   1      synchronous kill, returns to IDLE
//  out_valid_o  out  1      result valid; held until out_ready_i
//  out_ready_i  in   1      result consumed
//  result_o     out  ELEN   reduced scalar, zero-extended above SEW
//  busy_o       out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; acc, result_o, elem_base cleared; in_ready_o=0; out_valid_o=0; busy_o=0.
//  FSM: IDLE -start-> ACCUM (vl_i!=0) | DONE (vl_i==0, result=seed, no beats consumed).
//   ACCUM -accepted beat with in_last_i-> FOLD.
//   FOLD -after log2(VLEN/SEW) cycles-> SEED (1 cycle) -> DONE.
//   DONE -out_ready_i-> IDLE.
//  Start: acc <- identity in every lane; elem_base <- 0. in_ready_o=1 only in ACCUM.
//  Lane i of a beat is active iff (vm || in_mask_i[i]) && elem_base+i < vl.
//   Active lanes: acc[i]=op(acc[i],data[i]); inactive lanes: acc[i] unchanged.
//   Each beat: elem_base += VLEN/SEW, saturating at vl (no wrap).
//  Identity: SUM/OR/XOR/MAXU=0; AND/MINU=all-ones; MIN=0x7F..F; MAX=0x80..0 (SEW-wide).
//  FOLD: each cycle, lane j <- op(lane j, lane j+half); upper half <- identity; half halves.
//  SEED: result = op(acc lane 0, seed[SEW-1:0]). SUM wraps modulo 2^SEW.
//   MIN/MAX compare signed at SEW; MINU/MAXU compare unsigned.
//  Latency (last beat accepted -> out_valid_o): log2(VLEN/SEW)+2 cycles.
//   Sub-case: SEW=VLEN has zero FOLD cycles, so latency is 2.
//  start_i outside IDLE is ignored. Extra beats after vl are consumed, with all lanes inactive.
//  Beats with in_last_i=0 while in_valid_i=0 leave the state unchanged.
//  DONE with out_ready_i and start_i in the same cycle: return to IDLE only; start_i is ignored.
//  abort_i has priority in every state: next cycle IDLE, out_valid_o=0, partial result discarded.
//  Reset mid-operation: identical to power-on reset.
// TESTING
//  VLEN=64,SEW=8,SUM,vm=1,vl=8,data=01..08,seed=10 -> result 0x2E, 5 cycles after last beat.
//  SEW=16,MIN,vl=3,lanes {0005,FFFE,7000,8000},seed=0003 -> 0xFFFE (lane 3 beyond vl ignored).
//  SEW=32,MAXU,LMUL=4,vm=0,mask selects only beat 2 lane 1 = 0x9; others 0xFFFFFFFF -> max(9,seed).
//  vl=0,op=AND,seed=0xAB -> DONE immediately with result 0xAB; in_ready_o never asserted.
//  XOR, out_ready_i held 0 for 5 cycles -> result_o stable; start_i pulsed in DONE is ignored.
//  abort_i in FOLD, then new SUM start -> new result unaffected by the aborted accumulator.
//  reset_n low in ACCUM -> all outputs reset asynchronously.

Source files
------------

// File: rtl/vector_reduction_unit_if.sv
// Handshake/config bundle for vector_reduction_unit: start config, beat stream, result stream.
// master drives requests and consumes the result; slave is the reduction engine.
interface vector_reduction_unit_if #(
  parameter int VLEN     = 64,
  parameter int ELEN     = 64,
  parameter int LMUL_MAX = 8
);
  localparam int NLANE = VLEN / 8;
  localparam int VL_W  = $clog2(LMUL_MAX * VLEN / 8) + 1;

  logic              start;
  logic [2:0]        op;
  logic [1:0]        sew;
  logic [VL_W-1:0]   vl;
  logic              vm;
  logic [ELEN-1:0]   seed;
  logic              in_valid;
  logic              in_ready;
  logic [VLEN-1:0]   in_data;
  logic [NLANE-1:0]  in_mask;
  logic              in_last;
  logic              abort;
  logic              out_valid;
  logic              out_ready;
  logic [ELEN-1:0]   result;
  logic              busy;

  modport master (
    output start, op, sew, vl, vm, seed, in_valid, in_data, in_mask, in_last, abort, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  start, op, sew, vl, vm, seed, in_valid, in_data, in_mask, in_last, abort, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/vector_reduction_unit.sv
// vred*.vs engine: lane-wise beat accumulation, halving fold, then seed combine.
// One ALU array per legal SEW; the active SEW's array output is selected each cycle.

module vrd_lane #(
  parameter int W = 8
) (
  input  logic [2:0]   op,
  input  logic         act,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  logic         lt_u, lt_s;
  logic [W-1:0] r;

  assign lt_u = a < b;
  assign lt_s = $signed(a) < $signed(b);

  always_comb begin
    r = a + b;
    case (op)
      3'd1:    r = a & b;
      3'd2:    r = a | b;
      3'd3:    r = a ^ b;
      3'd4:    r = lt_u ? a : b;
      3'd5:    r = lt_s ? a : b;
      3'd6:    r = lt_u ? b : a;
      3'd7:    r = lt_s ? b : a;
      default: r = a + b;
    endcase
    y = act ? r : a;
  end
endmodule

module vector_reduction_unit #(
  parameter int VLEN     = 64,
  parameter int ELEN     = 64,
  parameter int LMUL_MAX = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  vector_reduction_unit_if.slave    io
);
  localparam int NLANE = VLEN / 8;
  localparam int VL_W  = $clog2(LMUL_MAX * VLEN / 8) + 1;
  localparam int HB_W  = $clog2(VLEN) + 1;

  typedef enum logic [2:0] {IDLE, ACCUM, FOLD, SEED, DONE} state_t;

  typedef struct packed {
    logic [2:0]      op;
    logic [1:0]      sew;
    logic [VL_W-1:0] vl;
    logic            vm;
    logic [ELEN-1:0] seed;
  } cfg_t;

  // Identity element replicated across every SEW-wide lane of a VLEN vector.
  function automatic logic [VLEN-1:0] ident_vec(input logic [2:0] op, input logic [1:0] sew);
    logic [VLEN-1:0] v;
    int              w;
    logic            msb;
    v = '0;
    w = 8 << sew;
    for (int b = 0; b < VLEN; b++) begin
      msb = ((b + 1) % w) == 0;
      case (op)
        3'd1, 3'd4: v[b] = 1'b1;
        3'd5:       v[b] = ~msb;
        3'd7:       v[b] = msb;
        default:    v[b] = 1'b0;
      endcase
    end
    return v;
  endfunction

  function automatic logic [ELEN-1:0] sew_mask(input logic [1:0] sew);
    logic [ELEN-1:0] m;
    for (int b = 0; b < ELEN; b++) m[b] = b < (8 << sew);
    return m;
  endfunction

  state_t               state_q, state_d;
  cfg_t                 cfg_q;
  logic [VLEN-1:0]      acc_q;
  logic [VL_W-1:0]      base_q, base_nxt;
  logic [VL_W:0]        base_sum;
  logic [HB_W-1:0]      half_q, sew_bits;
  logic [ELEN-1:0]      res_q;
  logic [3:0][VLEN-1:0] nxt_s;
  logic [VLEN-1:0]      nxt, opnd_b, keep_mask, id_q, fold_vec;
  logic                 beat, accum_mode, take_start;

  assign accum_mode = state_q == ACCUM;
  assign beat       = accum_mode && io.in_valid;
  assign take_start = state_q == IDLE && io.start && !io.abort;
  assign sew_bits   = HB_W'(8) << cfg_q.sew;

  // Second operand: incoming beat, the upper half of the accumulator, or the seed in lane 0.
  always_comb begin
    opnd_b = io.in_data;
    if (state_q == FOLD)      opnd_b = acc_q >> half_q;
    else if (state_q == SEED) opnd_b = VLEN'(cfg_q.seed);
  end

  for (genvar s = 0; s < 4; s++) begin : g_sew
    localparam int W = 8 << s;
    if (W <= ELEN && W <= VLEN) begin : g_ok
      localparam int NE = VLEN / W;
      logic [NE-1:0] act;
      for (genvar e = 0; e < NE; e++) begin : g_el
        logic [VL_W:0] idx;
        assign idx    = (VL_W+1)'(base_q) + (VL_W+1)'(e);
        assign act[e] = !accum_mode ||
                        ((cfg_q.vm || io.in_mask[e]) && idx < (VL_W+1)'(cfg_q.vl));
        vrd_lane #(.W(W)) u_lane (
          .op  (cfg_q.op),
          .act (act[e]),
          .a   (acc_q[e*W +: W]),
          .b   (opnd_b[e*W +: W]),
          .y   (nxt_s[s][e*W +: W])
        );
      end
    end else begin : g_na
      assign nxt_s[s] = acc_q;
    end
  end

  assign nxt       = nxt_s[cfg_q.sew];
  assign id_q      = ident_vec(cfg_q.op, cfg_q.sew);
  assign keep_mask = ~({VLEN{1'b1}} << half_q);
  assign fold_vec  = (nxt & keep_mask) | (id_q & ~keep_mask);

  // Element base advances by one beat's element count but never past vl.
  assign base_sum = (VL_W+1)'(base_q) + ((VL_W+1)'(NLANE) >> cfg_q.sew);
  assign base_nxt = (base_sum > (VL_W+1)'(cfg_q.vl)) ? cfg_q.vl : base_sum[VL_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    io.busy      = 1'b1;
    io.result    = res_q;
    case (state_q)
      IDLE: begin
        io.busy = 1'b0;
        if (io.start) state_d = (io.vl == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        io.in_ready = 1'b1;
        if (io.in_valid && io.in_last)
          state_d = (sew_bits >= HB_W'(VLEN)) ? SEED : FOLD;
      end
      FOLD:    if (half_q <= sew_bits) state_d = SEED;
      SEED:    state_d = DONE;
      DONE: begin
        io.out_valid = 1'b1;
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (io.abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_q  <= '0;
      acc_q  <= '0;
      base_q <= '0;
      half_q <= '0;
      res_q  <= '0;
    end else begin
      if (take_start) begin
        cfg_q  <= '{op: io.op, sew: io.sew, vl: io.vl, vm: io.vm, seed: io.seed};
        acc_q  <= ident_vec(io.op, io.sew);
        base_q <= '0;
        half_q <= HB_W'(VLEN / 2);
        if (io.vl == '0) res_q <= io.seed & sew_mask(io.sew);
      end
      if (beat) begin
        acc_q  <= nxt;
        base_q <= base_nxt;
      end
      if (state_q == FOLD) begin
        acc_q  <= fold_vec;
        half_q <= half_q >> 1;
      end
      if (state_q == SEED && !io.abort) res_q <= nxt[ELEN-1:0] & sew_mask(cfg_q.sew);
    end
  end

  a_excl: assert property (@(posedge clk) disable iff (!reset_n) !(io.in_ready && io.out_valid));
  a_busy: assert property (@(posedge clk) disable iff (!reset_n) io.out_valid |-> io.busy);
endmodule

// File: tb/tb_vector_reduction_unit.sv
// Randomized + directed bench for vector_reduction_unit against an element-list reference model.
`timescale 1ns/1ps
module tb_vector_reduction_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tot = 0;
  int   n_bad = 0;

  logic [63:0] bd [8];
  logic [7:0]  bm [8];
  logic [63:0] last_res;

  vector_reduction_unit_if #(.VLEN(64), .ELEN(64), .LMUL_MAX(8)) vif ();

  vector_reduction_unit #(.VLEN(64), .ELEN(64), .LMUL_MAX(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (vif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] ref_op(input int op, input int w, input logic [63:0] a,
                                         input logic [63:0] b);
    longint sa, sb;
    sa = $signed(a << (64 - w)) >>> (64 - w);
    sb = $signed(b << (64 - w)) >>> (64 - w);
    case (op)
      0: return (a + b) & wmask(w);
      1: return a & b;
      2: return a | b;
      3: return a ^ b;
      4: return (a < b) ? a : b;
      5: return (sa < sb) ? a : b;
      6: return (a > b) ? a : b;
      7: return (sa > sb) ? a : b;
      default: return a;
    endcase
  endfunction

  // Full reduction transaction: model, start, beats, latency, hold, handshake.
  task automatic run_red(input string tag, input int op, input int sew, input int vl,
                         input bit vm, input logic [63:0] seed, input int nb,
                         input int hold, input bit poke);
    int w, ne, lat;
    logic [63:0] m, exp, x;
    w = 8 << sew;
    ne = 64 / w;
    m = wmask(w);
    exp = seed & m;
    for (int b = 0; b < nb; b++)
      for (int e = 0; e < ne; e++) begin
        x = (bd[b] >> (e * w)) & m;
        if ((vm || bm[b][e]) && (b * ne + e) < vl) exp = ref_op(op, w, exp, x);
      end
    vif.start = 1'b1; vif.op = 3'(op); vif.sew = 2'(sew); vif.vl = 7'(vl);
    vif.vm = vm; vif.seed = seed;
    @(negedge clk);
    vif.start = 1'b0; vif.op = 3'($urandom); vif.sew = 2'($urandom); vif.vl = 7'($urandom);
    vif.vm = 1'($urandom); vif.seed = {$urandom, $urandom};
    if (vl == 0) begin
      chk({tag, ".rdy0"}, vif.in_ready, 64'd0);
    end else begin
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          vif.in_valid = 1'b0; vif.in_last = 1'b0; vif.in_data = {$urandom, $urandom};
          @(negedge clk);
        end
        vif.in_valid = 1'b1; vif.in_data = bd[b]; vif.in_mask = bm[b];
        vif.in_last = (b == nb - 1);
        @(negedge clk);
      end
      vif.in_valid = 1'b0; vif.in_last = 1'b0;
      lat = 1;
      while (!vif.out_valid && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      chk({tag, ".lat"}, 64'(lat), 64'($clog2(ne) + 2));
    end
    chk({tag, ".ovld"}, vif.out_valid, 64'd1);
    chk({tag, ".res"}, vif.result, exp);
    last_res = vif.result;
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 1) begin
        vif.start = 1'b1; vif.vl = 7'd5;
      end
      @(negedge clk);
      vif.start = 1'b0;
      chk({tag, ".hold"}, vif.result, exp);
      chk({tag, ".hvld"}, vif.out_valid, 64'd1);
    end
    vif.out_ready = 1'b1; vif.start = poke; vif.vl = 7'd5;
    @(negedge clk);
    vif.out_ready = 1'b0; vif.start = 1'b0;
    chk({tag, ".idle"}, vif.busy, 64'd0);
    chk({tag, ".ovld0"}, vif.out_valid, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_tot, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vif.start = 0; vif.op = 0; vif.sew = 0; vif.vl = 0; vif.vm = 0; vif.seed = 0;
    vif.in_valid = 0; vif.in_data = 0; vif.in_mask = 0; vif.in_last = 0;
    vif.abort = 0; vif.out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst.rdy", vif.in_ready, 64'd0);
    chk("rst.ovld", vif.out_valid, 64'd0);
    chk("rst.busy", vif.busy, 64'd0);
    chk("rst.res", vif.result, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Abort in FOLD, then the reference SUM case must be unaffected.
    vif.start = 1; vif.op = 0; vif.sew = 0; vif.vl = 7'd8; vif.vm = 1; vif.seed = 0;
    @(negedge clk);
    vif.start = 0;
    vif.in_valid = 1; vif.in_data = 64'hFFFF_FFFF_FFFF_FFFF; vif.in_mask = '1; vif.in_last = 1;
    @(negedge clk);
    vif.in_valid = 0; vif.in_last = 0;
    vif.abort = 1;
    @(negedge clk);
    vif.abort = 0;
    chk("abort.busy", vif.busy, 64'd0);
    chk("abort.ovld", vif.out_valid, 64'd0);
    bd[0] = 64'h0807_0605_0403_0201; bm[0] = '0;
    run_red("sum8", 0, 0, 8, 1'b1, 64'd10, 1, 0, 1'b0);
    chk("sum8.const", last_res, 64'h2E);

    bd[0] = 64'h8000_7000_FFFE_0005; bm[0] = '0;
    run_red("min16", 5, 1, 3, 1'b1, 64'h0003, 1, 0, 1'b0);
    chk("min16.const", last_res, 64'hFFFE);

    for (int b = 0; b < 4; b++) begin
      bd[b] = 64'hFFFF_FFFF_FFFF_FFFF; bm[b] = 8'h00;
    end
    bd[2] = 64'h0000_0009_FFFF_FFFF; bm[2] = 8'b10;
    run_red("maxu32", 6, 2, 8, 1'b0, 64'd5, 4, 0, 1'b0);
    chk("maxu32.const", last_res, 64'd9);

    run_red("vl0", 1, 0, 0, 1'b1, 64'hAB, 0, 0, 1'b0);
    chk("vl0.const", last_res, 64'hAB);

    bd[0] = {$urandom, $urandom};
    run_red("xorhold", 3, 0, 8, 1'b1, 64'h5A, 1, 5, 1'b1);

    bd[0] = 64'h1234_5678_9ABC_DEF0;
    run_red("sum64", 0, 3, 1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1'b0);

    // Asynchronous reset while accumulating.
    vif.start = 1; vif.op = 3; vif.sew = 0; vif.vl = 7'd16; vif.vm = 1; vif.seed = 64'h77;
    @(negedge clk);
    vif.start = 0; vif.in_valid = 1; vif.in_data = 64'h1111; vif.in_last = 0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.rdy", vif.in_ready, 64'd0);
    chk("arst.busy", vif.busy, 64'd0);
    chk("arst.ovld", vif.out_valid, 64'd0);
    chk("arst.res", vif.result, 64'd0);
    @(negedge clk);
    vif.in_valid = 0;
    reset_n = 1'b1;
    @(negedge clk);

    for (int it = 0; it < 24; it++) begin
      int sew, ne, nb, vl;
      sew = $urandom_range(0, 3);
      ne = 8 >> sew;
      nb = $urandom_range(1, 8);
      vl = $urandom_range(0, nb * ne + 1);
      for (int b = 0; b < 8; b++) begin
        bd[b] = {$urandom, $urandom};
        bm[b] = 8'($urandom);
      end
      run_red($sformatf("rnd%0d", it), $urandom_range(0, 7), sew, vl, 1'($urandom),
              {$urandom, $urandom}, nb, $urandom_range(0, 2), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
